fxp_div: RTL
============

# fxp_div

Sequential signed fixed-point divider: computes y = a / b for two N-bit two's-complement operands with FRAC fractional bits and returns an N-bit result in the same format. It is the inverse-direction counterpart of the fixed-point multiplier. It serves the filter datapath wherever a gain or normalisation needs a reciprocal or quotient. A radix-2 restoring long division produces one quotient bit per cycle, with valid/ready handshakes on both sides.

## Interface
- N, `FXP_N, total operand/result width
- FRAC, `FXP_FRAC, fractional bits (0 < FRAC < N)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands a, b presented
- in_ready  out  1  divider idle, can accept operands
- a  in  N  signed dividend, Q(N-FRAC).FRAC
- b  in  N  signed divisor, Q(N-FRAC).FRAC
- out_valid  out  1  result valid, held until consumed
- out_ready  in  1  consumer accepts result
- y  out  N  signed quotient, same format
- ovf  out  1  result saturated (quotient out of range)
- dbz  out  1  divide by zero (b == 0)

## Operation
- States:
  - IDLE: in_ready=1.
  - RUN: one quotient bit per cycle.
  - FIN: sign/saturation applied.
  - DONE: out_valid=1.
- IDLE→RUN on in_valid & in_ready.
- On accept, latch:
  - sign = a[N-1]^b[N-1]
  - |a|, |b| as N-bit unsigned (|−2^(N-1)| = 2^(N-1))
  - dividend D = |a| << FRAC (N+FRAC bits)
  - remainder R = 0 (N+1 bits)
  - counter = N+FRAC
  - dbz = (b == 0)
- RUN step, per cycle:
  - R = (R << 1) | D[MSB]; D <<= 1.
  - If R ≥ |b|: R -= |b| and shift 1 into Q; else shift 0.
  - Counter decrements; RUN→FIN when it reaches 0.
- Quotient Q is N+FRAC bits unsigned and truncated toward zero, matching the multiplier's truncation.
- FIN saturation:
  - Positive result: if Q > 2^(N-1)−1, y = 2^(N-1)−1 and ovf=1; else y = Q[N-1:0].
  - Negative result: if Q > 2^(N-1), y = −2^(N-1) and ovf=1; else y = −Q.
  - Q = 0 gives y = 0 regardless of sign (no −0 artefacts).
- Divide by zero:
  - Latency stays fixed; RUN still executes but its Q is ignored.
  - FIN forces y = 2^(N-1)−1 when a ≥ 0 and y = −2^(N-1) when a < 0.
  - dbz=1, ovf=0.
- DONE→IDLE on out_ready. y, ovf and dbz are held stable throughout DONE.
- Operand changes while not in IDLE are ignored. in_ready is low in RUN, FIN and DONE, so there is no overlap and no queueing.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, y=0, ovf=0, dbz=0; all internal registers 0.
- Latency:
  - Accept edge E0; RUN occupies edges E1..E(N+FRAC); FIN occurs at edge E(N+FRAC+1).
  - out_valid is high from the cycle after E(N+FRAC+1), i.e. N+FRAC+1 cycles after accept.
  - Latency is independent of operand values and dbz.
- Throughput: at most one operation per N+FRAC+3 cycles with out_ready held high.
- When out_ready is high on the first DONE cycle, out_valid lasts exactly one cycle.
- The earliest next accept is the cycle after the DONE→IDLE transition; in_ready is never high in the same cycle as out_valid.
- Async reset mid-RUN/FIN/DONE aborts immediately: outputs return to reset values and any pending result is discarded. After deassertion the block is in IDLE.
- in_ready and out_valid are decoded directly from registered state (no combinational path from in_valid or out_ready).

## Structure
- `fxp_types.vh` holds `FXP_N`, `FXP_FRAC` and the shared saturation constants (FXP_MAX = 2^(N-1)−1, FXP_MIN = −2^(N-1)). The state encoding is local to the block.
- Optional sub-module: `fxp_div_step`, a combinational single restoring step (R, D, |b| → R', D', qbit). It is isolated so it can later be unrolled two bits per cycle without touching the FSM.
- No other sub-modules; magnitude, sign and saturation logic stays inline.

## Test plan
Bench parameters: N=16, FRAC=8 (1.0 = 0x0100); latency = 25 cycles.
- Basic: a=0x0300, b=0x0200 → y=0x0180, ovf=0, dbz=0; out_valid rises exactly 25 cycles after accept.
- Sign and truncation: a=0xFF00 (−1.0), b=0x0300 → y=0xFFAB (−0x0055, truncated toward zero); a=0x0100, b=0xFD00 → y=0xFFAB.
- Saturation:
  - a=0x7FFF, b=0x0001 → y=0x7FFF, ovf=1.
  - a=0x8000, b=0x0100 → y=0x8000, ovf=0 (exact minimum).
  - a=0x8000, b=0xFF00 → y=0x7FFF, ovf=1.
- Divide by zero: b=0 with a=0x0100 → y=0x7FFF, dbz=1, ovf=0; a=0xFE00 → y=0x8000, dbz=1; a=0 → y=0x7FFF, dbz=1. Latency is 25 cycles in every case.
- Backpressure:
  - Hold out_ready=0 for 10 cycles: y, ovf, dbz and out_valid stay stable and in_ready stays 0, even with in_valid high and changing operands.
  - Release: next accept occurs one cycle after the out handshake, and the second result is correct.
- Reset mid-operation: assert rst_n=0 at cycle 10 of RUN → out_valid=0, y=0 and in_ready=1 immediately; after release, a fresh 0x0300/0x0200 yields 0x0180 with normal latency.

Source files
------------

// File: rtl/fxp_div_pkg.sv
// Shared fixed-point format for the filter datapath: default width, fraction bits
// and saturation limits common to the multiplier and divider.
package fxp_div_pkg;
  localparam int FXP_N    = 16;
  localparam int FXP_FRAC = 8;

  localparam logic [FXP_N-1:0] FXP_MAX = {1'b0, {(FXP_N-1){1'b1}}};
  localparam logic [FXP_N-1:0] FXP_MIN = {1'b1, {(FXP_N-1){1'b0}}};
endpackage

// File: rtl/fxp_div_step.sv
// One restoring long-division step: shift the next dividend bit into the
// partial remainder and subtract |b| when it fits.
module fxp_div_step
  import fxp_div_pkg::*;
#(
  parameter int N    = FXP_N,
  parameter int FRAC = FXP_FRAC
) (
  input  logic [N-1:0]      i_rem,
  input  logic [N+FRAC-1:0] i_dvd,
  input  logic [N-1:0]      i_absb,
  output logic [N-1:0]      o_rem,
  output logic [N+FRAC-1:0] o_dvd,
  output logic              o_qbit
);
  logic [N:0] w_shift;
  logic       w_ge;

  // the remainder stays below |b| <= 2^(N-1), so N bits hold it between steps
  assign w_shift = {i_rem, i_dvd[N+FRAC-1]};
  assign w_ge    = (w_shift >= {1'b0, i_absb});
  assign o_rem   = w_ge ? N'(w_shift - {1'b0, i_absb}) : w_shift[N-1:0];
  assign o_dvd   = {i_dvd[N+FRAC-2:0], 1'b0};
  assign o_qbit  = w_ge;
endmodule

// File: rtl/fxp_div.sv
// Sequential signed fixed-point divider y = a / b, one quotient bit per cycle,
// saturating, with valid/ready handshakes on both sides.
//  state  | meaning
//  S_IDLE | in_ready=1, waiting for operands
//  S_RUN  | one restoring step per cycle, N+FRAC cycles
//  S_FIN  | apply sign, saturation and divide-by-zero result
//  S_DONE | out_valid=1, result held until out_ready
module fxp_div
  import fxp_div_pkg::*;
#(
  parameter int N    = FXP_N,
  parameter int FRAC = FXP_FRAC
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] y,
  output logic         ovf,
  output logic         dbz
);
  localparam int QW = N + FRAC;
  localparam int CW = $clog2(QW + 1);

  localparam logic [N-1:0]  Y_MAX     = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]  Y_MIN     = {1'b1, {(N-1){1'b0}}};
  localparam logic [QW-1:0] Q_POS_LIM = {{(FRAC+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic [QW-1:0] Q_NEG_LIM = {{FRAC{1'b0}}, 1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN, S_DONE} state_t;

  state_t          r_state;
  logic            r_sign;
  logic            r_a_neg;
  logic            r_dbz;
  logic            r_ovf;
  logic [N-1:0]    r_y;
  logic [N-1:0]    r_absb;
  logic [N-1:0]    r_rem;
  logic [QW-1:0]   r_dvd;
  logic [QW-1:0]   r_q;
  logic [CW-1:0]   r_cnt;

  logic [N-1:0]    w_abs_a;
  logic [N-1:0]    w_abs_b;
  logic [N-1:0]    w_rem_nxt;
  logic [QW-1:0]   w_dvd_nxt;
  logic            w_qbit;

  // -(-2^(N-1)) wraps back to 2^(N-1), which is the correct unsigned magnitude
  assign w_abs_a = a[N-1] ? -a : a;
  assign w_abs_b = b[N-1] ? -b : b;

  fxp_div_step #(.N(N), .FRAC(FRAC)) u_step (
    .i_rem  (r_rem),
    .i_dvd  (r_dvd),
    .i_absb (r_absb),
    .o_rem  (w_rem_nxt),
    .o_dvd  (w_dvd_nxt),
    .o_qbit (w_qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sign  <= 1'b0;
      r_a_neg <= 1'b0;
      r_dbz   <= 1'b0;
      r_ovf   <= 1'b0;
      r_y     <= '0;
      r_absb  <= '0;
      r_rem   <= '0;
      r_dvd   <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sign  <= a[N-1] ^ b[N-1];
            r_a_neg <= a[N-1];
            r_absb  <= w_abs_b;
            r_dvd   <= {w_abs_a, {FRAC{1'b0}}};
            r_rem   <= '0;
            r_q     <= '0;
            r_cnt   <= CW'(QW);
            r_dbz   <= (b == '0);
            r_ovf   <= 1'b0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_rem <= w_rem_nxt;
          r_dvd <= w_dvd_nxt;
          r_q   <= {r_q[QW-2:0], w_qbit};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) r_state <= S_FIN;
        end
        S_FIN: begin
          // a zero divisor still runs the full step sequence; its quotient is discarded here
          if (r_dbz) begin
            r_y   <= r_a_neg ? Y_MIN : Y_MAX;
            r_ovf <= 1'b0;
          end else if (!r_sign) begin
            if (r_q > Q_POS_LIM) begin
              r_y   <= Y_MAX;
              r_ovf <= 1'b1;
            end else begin
              r_y   <= r_q[N-1:0];
              r_ovf <= 1'b0;
            end
          end else begin
            if (r_q > Q_NEG_LIM) begin
              r_y   <= Y_MIN;
              r_ovf <= 1'b1;
            end else begin
              r_y   <= -r_q[N-1:0];
              r_ovf <= 1'b0;
            end
          end
          r_state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign y         = r_y;
  assign ovf       = r_ovf;
  assign dbz       = r_dbz;
endmodule
